alu_seq_exec: RTL and testbench

- Execution-side consumer of the 4-bit ALU_OP code produced by the opcode decoder.
- Accepts an operation plus two operands over a valid/ready handshake and computes the result.
- Logic/arithmetic ops complete in one cycle. Shifts are iterative, one bit per cycle.
- Returns the result over a second valid/ready handshake. Sits between the ID/EX register and the EX/MEM stage, so the pipeline can stall on long shifts.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_comb_core.sv | 67 ++++++
 rtl/alu_seq_exec.sv | 176 +++++++++++++++++
 tb/tb_alu_seq_exec.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//
// Shared definitions for the execution-stage ALU and the opcode decoder that
// feeds it.
//
// Contents:
//   - ALU_OP_* : the nine legal 4-bit ALU_OP encodings. Codes 1001..1111 are
//                illegal.
//   - alu_state_e : control FSM states of alu_seq_exec (IDLE / SHIFT / DONE).
//   - alu_op_is_shift()   : true for sll / srl.
//   - alu_op_is_illegal() : true for any code above slt.
//
// Build option: ALU_FAST_SHIFT_EN (see alu_seq_exec). This package is the same
// in both builds.
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU_OP encodings. These values are shared with the decoder, so they must
    // not be renumbered.
    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b0001;
    localparam logic [3:0] ALU_OP_AND = 4'b0010;
    localparam logic [3:0] ALU_OP_OR  = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR = 4'b0100;
    localparam logic [3:0] ALU_OP_NOR = 4'b0101;
    localparam logic [3:0] ALU_OP_SLL = 4'b0110;
    localparam logic [3:0] ALU_OP_SRL = 4'b0111;
    localparam logic [3:0] ALU_OP_SLT = 4'b1000;

    // Control FSM states. SHIFT is only reachable in the iterative-shift build.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_e;

    function automatic logic alu_op_is_shift(input logic [3:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL);
    endfunction

    // Every code above slt is unused and is treated as illegal.
    function automatic logic alu_op_is_illegal(input logic [3:0] op);
        return (op > ALU_OP_SLT);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
//
// Purely combinational datapath of the ALU. It holds no state.
//
// Build option: ALU_FAST_SHIFT_EN
//   defined     : sll/srl are computed here with a barrel shifter. The amount
//                 is oper_b[SHAMT_W-1:0].
//   not defined : for sll/srl, comb_result passes oper_a through unchanged.
//                 alu_seq_exec loads this value and shifts it one bit per
//                 cycle.
//
// Parameters:
//   WIDTH   - operand/result width
//   SHAMT_W - shift-amount width. This parameter exists only in the
//             fast-shift build.
//
// Ports:
//   alu_op      in   4      operation code (see alu_pkg)
//   oper_a      in   WIDTH  operand A
//   oper_b      in   WIDTH  operand B
//   comb_result out  WIDTH  result. It is 0 for illegal codes.
//   illegal     out  1      alu_op is 1001..1111
// -----------------------------------------------------------------------------
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef ALU_FAST_SHIFT_EN
    ,
    parameter int SHAMT_W = 5
`endif
) (
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] oper_a,
    input  logic [WIDTH-1:0] oper_b,
    output logic [WIDTH-1:0] comb_result,
    output logic             illegal
);

    always_comb begin
        comb_result = '0;
        illegal     = alu_op_is_illegal(alu_op);

        case (alu_op)
            // Add and sub wrap modulo 2^WIDTH. Carry and overflow are dropped.
            ALU_OP_ADD: comb_result = oper_a + oper_b;
            ALU_OP_SUB: comb_result = oper_a - oper_b;
            ALU_OP_AND: comb_result = oper_a & oper_b;
            ALU_OP_OR:  comb_result = oper_a | oper_b;
            ALU_OP_XOR: comb_result = oper_a ^ oper_b;
            ALU_OP_NOR: comb_result = ~(oper_a | oper_b);
            ALU_OP_SLT: comb_result = {{(WIDTH-1){1'b0}},
                                       ($signed(oper_a) < $signed(oper_b))};
`ifdef ALU_FAST_SHIFT_EN
            ALU_OP_SLL: comb_result = oper_a << oper_b[SHAMT_W-1:0];
            ALU_OP_SRL: comb_result = oper_a >> oper_b[SHAMT_W-1:0];
`else
            // The sequencer shifts this value iteratively. It starts from A.
            ALU_OP_SLL,
            ALU_OP_SRL: comb_result = oper_a;
`endif
            default:    comb_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// -----------------------------------------------------------------------------
// alu_seq_exec
//
// Execution-stage ALU placed between ID/EX and EX/MEM.
//   - An operation is accepted on in_valid && in_ready.
//   - The result is returned on out_valid / out_ready.
//   - Logic and arithmetic ops produce out_valid one cycle after accept.
//   - In the default build, sll/srl shift one bit per cycle. Latency is
//     1 + amount, so upstream stalls while a long shift runs.
//
// Build option: ALU_FAST_SHIFT_EN
//   defined     : shifts use the barrel shifter in alu_comb_core and complete
//                 with latency 1. The SHIFT state, the counter and the
//                 direction flop are not built.
//   not defined : iterative shifter.
//   The handshake is the same in both builds.
//
// Parameters:
//   WIDTH   - operand/result width (default 32)
//   SHAMT_W - low bits of oper_b used as the shift amount. Must equal
//             log2(WIDTH).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active low
//   in_valid   in   1      upstream offers an operation
//   in_ready   out  1      high only in IDLE
//   alu_op     in   4      operation code (see alu_pkg)
//   oper_a     in   WIDTH  operand A. This is the value shifted by sll/srl.
//   oper_b     in   WIDTH  operand B. The shift amount is in [SHAMT_W-1:0].
//   out_valid  out  1      result/zero/illegal_op are valid
//   out_ready  in   1      downstream takes the result
//   result     out  WIDTH  registered result
//   zero       out  1      registered (result == 0)
//   illegal_op out  1      the accepted alu_op was 1001..1111
// -----------------------------------------------------------------------------
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] oper_a,
    input  logic [WIDTH-1:0] oper_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal_op
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

`ifndef ALU_FAST_SHIFT_EN
    // Shift bits still to perform, and the latched direction (1 = left).
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               dir_left_q, dir_left_d;
`endif

    logic [WIDTH-1:0] core_result;
    logic             core_illegal;
    logic             accept;

    alu_comb_core #(
        .WIDTH   (WIDTH)
`ifdef ALU_FAST_SHIFT_EN
        ,
        .SHAMT_W (SHAMT_W)
`endif
    ) u_core (
        .alu_op      (alu_op),
        .oper_a      (oper_a),
        .oper_b      (oper_b),
        .comb_result (core_result),
        .illegal     (core_illegal)
    );

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign accept     = in_valid && in_ready;
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        illegal_d  = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
        count_d    = count_q;
        dir_left_d = dir_left_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Illegal codes already give 0 from the core. A new
                    // accept clears a stale illegal flag.
                    result_d  = core_result;
                    illegal_d = core_illegal;
                    state_d   = ST_DONE;
`ifndef ALU_FAST_SHIFT_EN
                    if (alu_op_is_shift(alu_op)) begin
                        count_d    = oper_b[SHAMT_W-1:0];
                        dir_left_d = (alu_op == ALU_OP_SLL);
                        // A zero amount skips SHIFT. The result is oper_a.
                        if (oper_b[SHAMT_W-1:0] != '0) begin
                            state_d = ST_SHIFT;
                        end
                    end
`endif
                end
            end

`ifndef ALU_FAST_SHIFT_EN
            ST_SHIFT: begin
                result_d = dir_left_q ? (result_q << 1) : (result_q >> 1);
                count_d  = count_q - SHAMT_W'(1);
                // The shift made while the count is 1 is the last one.
                if (count_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                // result/zero/illegal hold until downstream takes them.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // zero follows the value written into result, so it always matches it.
        zero_d = (result_d == '0);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b1;
            illegal_q  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            count_q    <= '0;
            dir_left_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            illegal_q  <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
            count_q    <= count_d;
            dir_left_q <= dir_left_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_exec
//
// Directed and random operations are checked against a reference model. The
// model computes the expected result and latency directly from the operation
// definitions.
// -----------------------------------------------------------------------------
module tb_alu_seq_exec;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       alu_op = '0;
    logic [WIDTH-1:0] oper_a = '0;
    logic [WIDTH-1:0] oper_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal_op;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    alu_seq_exec #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .oper_a     (oper_a),
        .oper_b     (oper_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    // Reference model: the result of each operation from its definition.
    function automatic logic [31:0] model_result(input logic [3:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ~(a | b);
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from the accept edge to the first cycle with out_valid high.
    function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
        if (op == 4'd15) return 1;
        return b[0] ? 1 : 1;
`else
        if (op == 4'd6 || op == 4'd7) return 1 + int'(b[4:0]);
        return 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation: offer it, scramble the inputs after accept, wait for
    // out_valid, hold out_ready low for 'hold' cycles while offering junk, then
    // take the result.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_r;
        int          cycles;
        exp_r = model_result(op, a, b);
        check($sformatf("%s.idle_ready", tag), 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        alu_op    = op;
        oper_a    = a;
        oper_b    = b;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        oper_a   = $urandom;
        oper_b   = $urandom;
        cycles   = 1;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        check($sformatf("%s.latency", tag), 32'(cycles), 32'(model_latency(op, b)));
        check($sformatf("%s.out_valid", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s.result", tag), result, exp_r);
        check($sformatf("%s.zero", tag), 32'(zero), 32'(exp_r == 32'd0));
        check($sformatf("%s.illegal", tag), 32'(illegal_op), 32'(op > 4'd8));
        check($sformatf("%s.busy", tag), 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            alu_op   = 4'($urandom);
            oper_a   = $urandom;
            oper_b   = $urandom;
            tick();
            check($sformatf("%s.hold_valid", tag), 32'(out_valid), 32'd1);
            check($sformatf("%s.hold_result", tag), result, exp_r);
            check($sformatf("%s.hold_ready", tag), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("%s.drop_valid", tag), 32'(out_valid), 32'd0);
        check($sformatf("%s.back_ready", tag), 32'(in_ready), 32'd1);
        $display("txn %-10s op=%h a=%08h b=%08h exp=%08h lat=%0d hold=%0d",
                 tag, op, a, b, exp_r, cycles, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", 32'(zero), 32'd1);
        check("rst.illegal", 32'(illegal_op), 32'd0);
        rst = 1'b1;
        tick();

        // Directed cases
        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        run_op("sub_zero", 4'd1, 32'd5, 32'd5, 0);
        run_op("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("slt_pos", 4'd8, 32'd1, 32'hFFFF_FFFF, 0);
        run_op("sll_4", 4'd6, 32'd1, 32'h0000_0024, 0);
        run_op("srl_0", 4'd7, 32'h8000_0000, 32'd0, 0);
        run_op("srl_31", 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("illegal", 4'b1010, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op("clr_illeg", 4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        run_op("nor_bp3", 4'd5, 32'h0000_FFFF, 32'h00FF_0000, 3);
        run_op("sll_bp3", 4'd6, 32'h0000_0003, 32'h0000_0007, 3);

        // Reset in the middle of a long shift
        in_valid = 1'b1;
        alu_op   = 4'd6;
        oper_a   = 32'd1;
        oper_b   = 32'd20;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("midrst.busy", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.result", result, 32'd0);
        check("midrst.zero", 32'(zero), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        run_op("post_rst", 4'd0, 32'd100, 32'd23, 0);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (n % 5 == 0) b = a;  // exercises equal operands and zero results
            run_op($sformatf("rnd%0d", n), op, a, b, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
